// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MD_* op encodings as presented on the op bus
//   md_state_e: sequencer states IDLE -> CALC -> FIX
//   MD_ITERS: radix-2 steps per operation (one per operand bit)
package muldiv_unit_pkg;

   localparam int unsigned MD_ITERS = 32;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_FIX
   } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling for the multiply/divide unit.
// Operand side: converts in1/in2 to magnitudes when op_signed, reporting their signs.
// Result side: applies the sign correction to the raw 64-bit datapath result.
//   Multiply: whole product negated when neg_q.
//   Divide:   quotient (low half) negated when neg_q, remainder (high half) when neg_r.
// Ports:
//   op_signed            in   operands are two's complement
//   in1, in2             in   raw operands
//   abs1, abs2           out  operand magnitudes
//   sign1, sign2         out  operand was negative (signed ops only)
//   res_raw              in   {hi, lo} magnitude result from the datapath
//   res_is_div           in   result is {remainder, quotient}
//   neg_q, neg_r         in   negate quotient/product, negate remainder
//   res_fixed            out  sign-corrected {hi, lo}
module md_sign_fix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 op_signed,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   output logic [WIDTH-1:0]     abs1,
   output logic [WIDTH-1:0]     abs2,
   output logic                 sign1,
   output logic                 sign2,
   input  logic [2*WIDTH-1:0]   res_raw,
   input  logic                 res_is_div,
   input  logic                 neg_q,
   input  logic                 neg_r,
   output logic [2*WIDTH-1:0]   res_fixed
);

   always_comb begin
      sign1 = op_signed & in1[WIDTH-1];
      sign2 = op_signed & in2[WIDTH-1];
      // The most negative value maps onto itself, which is the correct unsigned magnitude.
      abs1  = sign1 ? -in1 : in1;
      abs2  = sign2 ? -in2 : in2;

      res_fixed = res_raw;
      if (res_is_div) begin
         if (neg_q) res_fixed[WIDTH-1:0]       = -res_raw[WIDTH-1:0];
         if (neg_r) res_fixed[2*WIDTH-1:WIDTH] = -res_raw[2*WIDTH-1:WIDTH];
      end else if (neg_q) begin
         res_fixed = -res_raw;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// One op per start pulse; mult/div run a fixed 34-edge sequence (latch, 32 steps, fix-up)
// and finish with a one-cycle done pulse as hi/lo update. MTHI/MTLO write immediately.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       request and operation (sampled only while idle)
//   in1, in2        rs / rt operands
//   flush           abort the op in flight, hi/lo untouched
//   busy, done      op in flight, result-written pulse
//   hi, lo          HI/LO registers
//   div_zero        only when MULDIV_DIV0_FLAG_EN is defined: pulses with done for a
//                   divide whose divisor was zero
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
   ,
   output logic             div_zero
`endif
);

   md_state_e            state_q;
   logic [5:0]           count_q;
   logic [2*WIDTH-1:0]   acc_q;     // mult: {partial product, multiplier}; div: {rem, quo}
   logic [WIDTH-1:0]     opb_q;     // multiplicand or divisor magnitude
   logic                 is_div_q;
   logic                 neg_q_q;
   logic                 neg_r_q;
   logic                 div0_q;
   logic                 busy_q;
   logic                 done_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
   logic                 div_zero_q;
`endif

   logic                 op_signed;
   logic [WIDTH-1:0]     abs1;
   logic [WIDTH-1:0]     abs2;
   logic                 sign1;
   logic                 sign2;
   logic [2*WIDTH-1:0]   res_fixed;

   assign op_signed = (op == MD_MULT) || (op == MD_DIV);

   md_sign_fix #(
      .WIDTH (WIDTH)
   ) u_sign_fix (
      .op_signed  (op_signed),
      .in1        (in1),
      .in2        (in2),
      .abs1       (abs1),
      .abs2       (abs2),
      .sign1      (sign1),
      .sign2      (sign2),
      .res_raw    (acc_q),
      .res_is_div (is_div_q),
      .neg_q      (neg_q_q),
      .neg_r      (neg_r_q),
      .res_fixed  (res_fixed)
   );

   // One radix-2 step through a shared 33-bit adder/subtractor (extra bit is the borrow).
   logic [WIDTH:0]       add_a;
   logic [WIDTH:0]       add_b;
   logic [WIDTH+1:0]     add_res;
   logic [2*WIDTH-1:0]   acc_step;

   always_comb begin
      if (is_div_q) begin
         add_a   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
         add_b   = {1'b0, opb_q};
         add_res = {1'b0, add_a} - {1'b0, add_b};
         // Restoring division: keep the difference only when it did not borrow.
         if (!add_res[WIDTH+1]) begin
            acc_step = {add_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
         end
      end else begin
         add_a    = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
         add_b    = acc_q[0] ? {1'b0, opb_q} : '0;
         add_res  = {1'b0, add_a} + {1'b0, add_b};
         // Shift-add: carry-out becomes the new top bit as the multiplier shifts out.
         acc_step = {add_res[WIDTH:0], acc_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MD_IDLE;
         count_q    <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         is_div_q   <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         div0_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         done_q     <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
         div_zero_q <= 1'b0;
`endif
         unique case (state_q)
            MD_IDLE: begin
               if (start && !flush) begin
                  unique case (op)
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        state_q  <= MD_CALC;
                        busy_q   <= 1'b1;
                        count_q  <= '0;
                        acc_q    <= {{WIDTH{1'b0}}, abs1};
                        opb_q    <= abs2;
                        is_div_q <= op[1];
                        neg_q_q  <= sign1 ^ sign2;
                        neg_r_q  <= sign1;
                        div0_q   <= op[1] && (in2 == '0);
                     end
                     MD_MTHI: hi_q <= in1;
                     MD_MTLO: lo_q <= in1;
                     default: ;
                  endcase
               end
            end
            MD_CALC: begin
               if (flush) begin
                  state_q <= MD_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q   <= acc_step;
                  count_q <= count_q + 6'd1;
                  if (count_q == 6'(MD_ITERS - 1)) state_q <= MD_FIX;
               end
            end
            MD_FIX: begin
               state_q <= MD_IDLE;
               busy_q  <= 1'b0;
               if (!flush) begin
                  // Sign-corrected remainder equals the raw dividend on divide-by-zero.
                  hi_q   <= res_fixed[2*WIDTH-1:WIDTH];
                  lo_q   <= div0_q ? '1 : res_fixed[WIDTH-1:0];
                  done_q <= 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
                  div_zero_q <= div0_q;
`endif
               end
            end
            default: begin
               state_q <= MD_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
   assign div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written sequences for
// start-while-busy, back-to-back MTLO, flush and mid-op reset, and random ops checked
// against an arithmetic reference model. Honours MULDIV_DIV0_FLAG_EN when defined.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
   logic        div_zero;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_unit #(
      .WIDTH (32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .in1      (in1),
      .in2      (in2),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
`ifdef MULDIV_DIV0_FLAG_EN
      ,
      .div_zero (div_zero)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (o)
         MD_MULT:  return 64'(sa * sb);
         MD_MULTU: return ua * ub;
         MD_DIV: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {(ua % ub) & 64'hFFFF_FFFF} << 32 | ((ua / ub) & 64'hFFFF_FFFF);
         end
      endcase
   endfunction

   // Issue an op from an idle cycle (#1 after an edge) and wait for done.
   // Returns in the done cycle; lat counts edges after the sampling edge E0.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output int lat,
                         output logic dz);
      op = o; in1 = a; in2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy after start", 64'(busy), 64'd1);
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      rh = hi;
      rl = lo;
`ifdef MULDIV_DIV0_FLAG_EN
      dz = div_zero;
`else
      dz = 1'b0;
`endif
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t        vecs[10];
   logic [31:0] rh, rl;
   logic [63:0] exp_res;
   int          lat;
   int          n;
   logic        dz;
   logic        seen_done;
   logic [2:0]  rop;
   logic [31:0] ra, rb;

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; in1 = '0; in2 = '0;

      vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{MD_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
      vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      vecs[5] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      vecs[6] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
      vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[8] = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[9] = '{MD_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, issued back-to-back from each done cycle.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, lat, dz);
         check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
         check($sformatf("vec%0d hi", i), 64'(rh), 64'(vecs[i].hi));
         check($sformatf("vec%0d lo", i), 64'(rl), 64'(vecs[i].lo));
`ifdef MULDIV_DIV0_FLAG_EN
         check($sformatf("vec%0d div_zero", i), 64'(dz),
               64'(vecs[i].op[1] && vecs[i].b == 32'h0));
`endif
      end
      @(posedge clk); #1;
      check("done single cycle", 64'(done), 64'd0);

      // Starts while busy are ignored; MTLO taken in the done cycle.
      op = MD_DIVU; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!done && n < 100) begin
         start = (n == 4) || (n == 9);
         op    = (n == 4) ? MD_MULT : MD_MTHI;
         in1   = 32'h5555;
         in2   = 32'd3;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check("busy-start latency", 64'(n), 64'd33);
      check("busy-start hi", 64'(hi), 64'd2);
      check("busy-start lo", 64'(lo), 64'd14);
      op = MD_MTLO; in1 = 32'hABCD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("mtlo in done cycle lo", 64'(lo), 64'hABCD);
      check("mtlo in done cycle busy", 64'(busy), 64'd0);

      // MTHI, flush-over-start in idle, then flush mid-op.
      op = MD_MTHI; in1 = 32'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("mthi hi", 64'(hi), 64'h1234);
      check("mthi no done", 64'(done), 64'd0);
      op = MD_MTHI; in1 = 32'h9999; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush beats start", 64'(hi), 64'h1234);
      op = MD_MULTU; in1 = 32'd2; in2 = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen_done |= done | busy;
      end
      check("flush no done", 64'(seen_done), 64'd0);
      check("flush hi kept", 64'(hi), 64'h1234);
      check("flush lo kept", 64'(lo), 64'hABCD);

      // Random ops against the reference model.
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'h0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         exp_res = model(rop, ra, rb);
         run_op(rop, ra, rb, rh, rl, lat, dz);
         check($sformatf("rand%0d op%0d %h,%h latency", i, rop, ra, rb), 64'(lat), 64'd33);
         check($sformatf("rand%0d op%0d %h,%h result", i, rop, ra, rb), {rh, rl}, exp_res);
      end

      // Asynchronous reset mid-divide, then a fresh op.
      @(posedge clk); #1;
      op = MD_DIV; in1 = 32'hFFFF_FF9C; in2 = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset busy", 64'(busy), 64'd0);
      check("async reset hi", 64'(hi), 64'd0);
      check("async reset lo", 64'(lo), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(MD_MULTU, 32'd6, 32'd7, rh, rl, lat, dz);
      check("post-reset latency", 64'(lat), 64'd33);
      check("post-reset lo", 64'(rl), 64'd42);
      check("post-reset hi", 64'(rh), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
